// File: rtl/uart_tx_queue.sv
// Byte FIFO plus transmit sequencer feeding the io_hub UART transmitter.
// Bytes are popped one at a time and tracked through is_transmitting so none are lost or repeated.
//
// state      | meaning
// -----------|-----------------------------------------------------------
// IDLE       | waiting for a queued byte and an idle UART; pops on entry to SEND
// SEND       | transmit pulse high for this single cycle
// WAIT_BUSY  | waiting for the UART to raise is_transmitting; times out to IDLE
// WAIT_IDLE  | UART is shifting the byte out; waiting for it to finish

module uart_tx_queue #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              flush,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    input  logic              is_transmitting,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              busy,
    output logic              tx_err
);

    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_t;

    state_t              state_q;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [TMO_W-1:0]    tmo_q;
    logic [7:0]          tx_byte_q;
    logic                transmit_q;
    logic                tx_err_q;
    logic                push, pop;

    // Ready looks only at the registered count, so a full FIFO never admits a push in its pop cycle.
    assign s_ready  = rst_n && (count_q != FULL_LVL);
    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
    assign tx_err   = tx_err_q;
    assign level    = count_q;
    assign empty    = (count_q == '0);
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        push     = s_valid && s_ready && !flush;
        pop      = (state_q == ST_IDLE) && (count_q != '0) && !is_transmitting && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            tx_byte_q  <= 8'h00;
            transmit_q <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            transmit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        tx_byte_q  <= mem[rd_ptr_q];
                        transmit_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (is_transmitting) begin
                        state_q <= ST_WAIT_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                        // The UART never picked the byte up; it is dropped, not retried.
                        if (tmo_q == TMO_LAST) begin
                            tx_err_q <= 1'b1;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!is_transmitting) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Byte queue and transmit sequencer that sits directly upstream of the io_hub UART transmitter. It accepts bytes from the bus side over a valid/ready handshake and buffers them in a circular FIFO. It then issues them one at a time to the UART, pulsing transmit and holding tx_byte. Each byte is tracked through the UART's is_transmitting flag so that no byte is lost or duplicated.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
ADDR_W, 4, log2(DEPTH); pointer width.
BUSY_TIMEOUT, 4, cycles to wait for is_transmitting to rise after a transmit pulse before flagging an error.

Ports:
clk  in  1  single clock; all logic posedge.
rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
s_valid  in  1  upstream byte valid.
s_data  in  8  upstream byte.
s_ready  out  1  queue can accept; high when count != DEPTH.
flush  in  1  synchronous FIFO clear; does not abort the in-flight byte.
transmit  out  1  one-cycle pulse to the UART transmitter.
tx_byte  out  8  byte to the UART; stable from the pulse until the next pop.
is_transmitting  in  1  UART transmitter busy flag.
level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
empty  out  1  level == 0.
busy  out  1  sequencer FSM not in IDLE.
tx_err  out  1  sticky; UART never went busy after a pulse; cleared only by reset.

Behaviour:
- Reset (rst_n low at posedge): count = 0, wr_ptr = 0, rd_ptr = 0, FSM = IDLE, timeout counter = 0.
  - Output values: transmit = 0, tx_byte = 8'h00, tx_err = 0, level = 0, empty = 1, busy = 0.
  - s_ready is forced to 0 while rst_n is low; it is 1 on the first cycle after release.
- FIFO push: occurs when s_valid && s_ready. Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH (natural wrap).
- s_ready depends only on the registered count. When full, a pop in the same cycle does not admit a push; the push is admitted the following cycle.
- Pop: occurs only in the IDLE transition described below. A push into an empty FIFO is poppable no earlier than the next cycle; there is no fall-through.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- flush: count, wr_ptr and rd_ptr go to 0.
  - flush has priority over a push in the same cycle; that push is dropped, and the upstream sees s_ready high, so it is lost by design.
  - The FSM and tx_byte are unaffected.
- FSM states and transitions:
  - IDLE: if count != 0 && !is_transmitting && !flush, then tx_byte <= mem[rd_ptr], rd_ptr++, count--, go to SEND. Otherwise stay.
  - SEND: transmit = 1 for exactly this cycle, driven from a registered state decode with no combinational path from inputs. Go to WAIT_BUSY with timeout counter = 0.
  - WAIT_BUSY:
    - If is_transmitting, go to WAIT_IDLE.
    - Otherwise increment the timeout counter.
    - When the counter reaches BUSY_TIMEOUT, set tx_err = 1 and go to IDLE. The byte is not retried.
  - WAIT_IDLE: when !is_transmitting, go to IDLE.
- Latency:
  - Push at edge N into an idle, empty queue: pop at N+1, transmit high during cycle N+2.
  - UART busy is expected during N+3.
- Back-to-back bytes: the next pop happens in the first IDLE cycle after is_transmitting falls. Minimum gap is one IDLE cycle between is_transmitting low and the next SEND cycle.
- transmit is never asserted while is_transmitting is high, and never on two consecutive cycles.
- Mid-operation reset: the in-flight byte and all queued bytes are discarded. transmit is 0 from the reset edge onward. The UART is reset separately.

Test Plan:
1. Reset, then push 8'hA5 once → level goes 1 then 0. transmit pulses exactly one cycle, 2 cycles after the push edge, with tx_byte = 8'hA5. busy remains high until the UART model drops is_transmitting.
2. Push 16 bytes 8'h00..8'h0F back-to-back with the UART model held busy → s_ready falls after the 16th and level = 16. A 17th s_valid is not accepted. On release the bytes emerge in order 00..0F with one pulse each, across wrap-around of both pointers.
3. Full FIFO, s_valid held high while a pop occurs → no push in the pop cycle; the push is accepted the next cycle and level returns to 16.
4. UART model never asserts is_transmitting after a pulse → tx_err = 1 exactly BUSY_TIMEOUT cycles into WAIT_BUSY. The FSM returns to IDLE and the next queued byte is sent. tx_err stays 1 until rst_n is low.
5. Queue 5 bytes, then assert flush while the first byte is in WAIT_IDLE → level = 0 and empty = 1 next cycle. The in-flight byte completes and no further transmit pulse follows.
6. Assert rst_n low during WAIT_BUSY with 3 bytes queued → next cycle: transmit = 0, level = 0, busy = 0, tx_byte = 8'h00, and s_ready = 1 after release.
